// File: rtl/rf_pkg.sv
// Shared defaults and constants for the multi-port register file.
package rf_pkg;

   localparam int RF_DW    = 32;
   localparam int RF_AW    = 5;
   localparam int RF_DEPTH = 2**RF_AW;
   localparam int RF_ZERO  = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard. A producer issue sets the bit and a
// writeback clears it. When both target the same register in one cycle,
// the set wins because a newer producer is now in flight. The hardwired
// zero register never becomes pending.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int AW       = RF_AW,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_a,
   input  logic          we0,
   input  logic [AW-1:0] wa0,
   input  logic          we1,
   input  logic [AW-1:0] wa1,
   input  logic [AW-1:0] a1,
   input  logic [AW-1:0] a2,
   output logic          pend1,
   output logic          pend2
);

   localparam int DEPTH = 2**AW;

   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;

   // Next pending state: clears from writebacks first, then set overrides.
   always_comb begin
      pend_d = pend_q;
      if (we0) pend_d[wa0] = 1'b0;
      if (we1) pend_d[wa1] = 1'b0;
      if (set_en) pend_d[set_a] = 1'b1;
      if (ZERO_REG) pend_d[RF_ZERO] = 1'b0;
   end

   // Pending vector register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   assign pend1 = pend_q[a1];
   assign pend2 = pend_q[a2];

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file: two prioritised write ports, two combinational
// read ports with optional same-cycle forwarding, an optional hardwired zero
// register and a pending scoreboard for the multicycle controller.
module rf_mp
   import rf_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] A1,
   input  logic [AW-1:0] A2,
   output logic [DW-1:0] RD1,
   output logic [DW-1:0] RD2,
   output logic          PEND1,
   output logic          PEND2,
   input  logic          WE0,
   input  logic [AW-1:0] WA0,
   input  logic [DW-1:0] WD0,
   input  logic          WE1,
   input  logic [AW-1:0] WA1,
   input  logic [DW-1:0] WD1,
   input  logic          SET_EN,
   input  logic [AW-1:0] SET_A
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0] rf_q [DEPTH];
   logic [DW-1:0] rf_d [DEPTH];
   logic          sb_pend1;
   logic          sb_pend2;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == AW'(RF_ZERO));
   endfunction

   // True when a write this cycle targets address a.
   function automatic logic wr_hit(input logic [AW-1:0] a,
                                   input logic we0, input logic [AW-1:0] wa0,
                                   input logic we1, input logic [AW-1:0] wa1);
      return (we1 && (wa1 == a)) || (we0 && (wa0 == a));
   endfunction

   // Read value for address a: zero register first, then port 1, then
   // port 0 forwarding, then the stored array word.
   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a,
                                            input logic [DW-1:0] arr,
                                            input logic we0, input logic [AW-1:0] wa0,
                                            input logic [DW-1:0] wd0,
                                            input logic we1, input logic [AW-1:0] wa1,
                                            input logic [DW-1:0] wd1);
      if (is_zero(a))                    return '0;
      if (BYPASS && we1 && (wa1 == a))   return wd1;
      if (BYPASS && we0 && (wa0 == a))   return wd0;
      return arr;
   endfunction

   rf_scoreboard #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .set_en (SET_EN),
      .set_a  (SET_A),
      .we0    (WE0),
      .wa0    (WA0),
      .we1    (WE1),
      .wa1    (WA1),
      .a1     (A1),
      .a2     (A2),
      .pend1  (sb_pend1),
      .pend2  (sb_pend2)
   );

   // Next array state: port 0 applied first so port 1 wins a collision.
   always_comb begin
      rf_d = rf_q;
      if (WE0 && !is_zero(WA0)) rf_d[WA0] = WD0;
      if (WE1 && !is_zero(WA1)) rf_d[WA1] = WD1;
   end

   // Data array register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   // Read ports; forwarding and pending are suppressed while in reset.
   always_comb begin
      RD1   = '0;
      RD2   = '0;
      PEND1 = 1'b0;
      PEND2 = 1'b0;
      if (!rst) begin
         RD1   = rd_val(A1, rf_q[A1], WE0, WA0, WD0, WE1, WA1, WD1);
         RD2   = rd_val(A2, rf_q[A2], WE0, WA0, WD0, WE1, WA1, WD1);
         PEND1 = sb_pend1 && !(BYPASS && wr_hit(A1, WE0, WA0, WE1, WA1));
         PEND2 = sb_pend2 && !(BYPASS && wr_hit(A2, WE0, WA0, WE1, WA1));
      end
   end

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: a bypassing and a non-bypassing 32-bit instance
// share stimulus; a 16-bit/8-entry non-bypassing instance covers the sweep.
module tb_rf_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        we0, we1, set_en;
   logic [4:0]  wa0, wa1, set_a, a1, a2;
   logic [31:0] wd0, wd1;
   logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
   logic        b_p1, b_p2, n_p1, n_p2;

   logic        s_we0, s_we1, s_set_en;
   logic [2:0]  s_wa0, s_wa1, s_set_a, s_a1, s_a2;
   logic [15:0] s_wd0, s_wd1, s_rd1, s_rd2;
   logic        s_p1, s_p2;

   rf_mp #(.DW(32), .AW(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
      .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(b_rd1), .RD2(b_rd2),
      .PEND1(b_p1), .PEND2(b_p2), .WE0(we0), .WA0(wa0), .WD0(wd0),
      .WE1(we1), .WA1(wa1), .WD1(wd1), .SET_EN(set_en), .SET_A(set_a));

   rf_mp #(.DW(32), .AW(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
      .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(n_rd1), .RD2(n_rd2),
      .PEND1(n_p1), .PEND2(n_p2), .WE0(we0), .WA0(wa0), .WD0(wd0),
      .WE1(we1), .WA1(wa1), .WD1(wd1), .SET_EN(set_en), .SET_A(set_a));

   rf_mp #(.DW(16), .AW(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_s (
      .clk(clk), .rst(rst), .A1(s_a1), .A2(s_a2), .RD1(s_rd1), .RD2(s_rd2),
      .PEND1(s_p1), .PEND2(s_p2), .WE0(s_we0), .WA0(s_wa0), .WD0(s_wd0),
      .WE1(s_we1), .WA1(s_wa1), .WD1(s_wd1), .SET_EN(s_set_en), .SET_A(s_set_a));

   typedef struct {
      int unsigned we0; int unsigned wa0; logic [31:0] wd0;
      int unsigned we1; int unsigned wa1; logic [31:0] wd1;
      int unsigned se;  int unsigned sa;
      int unsigned a1;  int unsigned a2;
      logic [31:0] b_rd1; int unsigned b_p1; logic [31:0] b_rd2; int unsigned b_p2;
      logic [31:0] n_rd1; int unsigned n_p1;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      set_en = 1'b0; set_a = '0;
   endtask

   initial begin
      //        we0 wa0 wd0           we1 wa1 wd1           se sa  a1  a2   b_rd1         bp1 b_rd2         bp2 n_rd1        np1
      vecs[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  7,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[1]  = '{1, 5,  32'h12345678, 0, 0,  32'h0,        0, 0,  5,  5,  32'h12345678, 0, 32'h12345678, 0, 32'h0,        0};
      vecs[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  7,  32'h12345678, 0, 32'h0,        0, 32'h12345678, 0};
      vecs[3]  = '{1, 7,  32'h1111,     1, 7,  32'h2222,     0, 0,  7,  5,  32'h2222,     0, 32'h12345678, 0, 32'h0,        0};
      vecs[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  7,  32'h2222,     0, 32'h2222,     0, 32'h2222,     0};
      vecs[5]  = '{0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 3,  3,  3,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  3,  3,  32'h0,        1, 32'h0,        1, 32'h0,        1};
      vecs[9]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  3,  3,  32'h0,        1, 32'h0,        1, 32'h0,        1};
      vecs[10] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  3,  3,  32'h0,        1, 32'h0,        1, 32'h0,        1};
      vecs[11] = '{1, 3,  32'h55,       0, 0,  32'h0,        0, 0,  3,  3,  32'h55,       0, 32'h55,       0, 32'h0,        1};
      vecs[12] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  3,  3,  32'h55,       0, 32'h55,       0, 32'h55,       0};
      vecs[13] = '{0, 0,  32'h0,        1, 9,  32'hAB,       1, 9,  9,  9,  32'hAB,       0, 32'hAB,       0, 32'h0,        0};
      vecs[14] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9,  9,  32'hAB,       1, 32'hAB,       1, 32'hAB,       1};
      vecs[15] = '{0, 0,  32'h0,        1, 9,  32'hCD,       0, 0,  9,  3,  32'hCD,       0, 32'h55,       0, 32'hAB,       1};
      vecs[16] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9,  9,  32'hCD,       0, 32'hCD,       0, 32'hCD,       0};
      vecs[17] = '{1, 10, 32'hA0A0,     1, 11, 32'hB1B1,     0, 0,  10, 11, 32'hA0A0,     0, 32'hB1B1,     0, 32'h0,        0};
      vecs[18] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  10, 11, 32'hA0A0,     0, 32'hB1B1,     0, 32'hA0A0,     0};

      idle_inputs();
      a1 = 5'd5; a2 = 5'd7;
      s_we0 = 1'b0; s_wa0 = '0; s_wd0 = '0;
      s_we1 = 1'b0; s_wa1 = '0; s_wd1 = '0;
      s_set_en = 1'b0; s_set_a = '0; s_a1 = 3'd0; s_a2 = 3'd7;

      // Reset state while rst is held.
      #12;
      chk("rst b_rd1", b_rd1, 32'h0);
      chk("rst b_p1", 32'(b_p1), 32'h0);
      chk("rst n_rd1", n_rd1, 32'h0);
      chk("rst s_rd2", 32'(s_rd2), 32'h0);

      @(negedge clk);
      rst = 1'b0;

      // Table-driven single-cycle vectors, checked mid-cycle before the edge.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         we0 = vecs[i].we0[0]; wa0 = vecs[i].wa0[4:0]; wd0 = vecs[i].wd0;
         we1 = vecs[i].we1[0]; wa1 = vecs[i].wa1[4:0]; wd1 = vecs[i].wd1;
         set_en = vecs[i].se[0]; set_a = vecs[i].sa[4:0];
         a1 = vecs[i].a1[4:0]; a2 = vecs[i].a2[4:0];
         #2;
         chk($sformatf("v%0d b_rd1", i), b_rd1, vecs[i].b_rd1);
         chk($sformatf("v%0d b_pend1", i), 32'(b_p1), vecs[i].b_p1);
         chk($sformatf("v%0d b_rd2", i), b_rd2, vecs[i].b_rd2);
         chk($sformatf("v%0d b_pend2", i), 32'(b_p2), vecs[i].b_p2);
         chk($sformatf("v%0d n_rd1", i), n_rd1, vecs[i].n_rd1);
         chk($sformatf("v%0d n_pend1", i), 32'(n_p1), vecs[i].n_p1);
      end

      // Mid-cycle reset pulse after writing r5 and marking it pending.
      @(negedge clk);
      idle_inputs();
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF;
      set_en = 1'b1; set_a = 5'd5;
      a1 = 5'd5; a2 = 5'd5;
      #2;
      chk("pre-rst b_rd1", b_rd1, 32'hDEADBEEF);
      chk("pre-rst n_rd1", n_rd1, 32'h12345678);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("stored b_rd1", b_rd1, 32'hDEADBEEF);
      chk("stored b_pend1", 32'(b_p1), 32'h1);
      chk("stored n_rd1", n_rd1, 32'hDEADBEEF);
      #1;
      rst = 1'b1;
      #1;
      chk("in-rst b_rd1", b_rd1, 32'h0);
      chk("in-rst b_pend1", 32'(b_p1), 32'h0);
      chk("in-rst n_rd1", n_rd1, 32'h0);
      chk("in-rst n_pend1", 32'(n_p1), 32'h0);
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hFFFFFFFF;
      #1;
      chk("in-rst bypass b_rd1", b_rd1, 32'h0);
      we1 = 1'b0; wd1 = '0;
      rst = 1'b0;
      @(negedge clk);
      #2;
      chk("post-rst b_rd1", b_rd1, 32'h0);
      chk("post-rst b_pend1", 32'(b_p1), 32'h0);
      chk("post-rst n_rd1", n_rd1, 32'h0);
      a1 = 5'd9;
      #1;
      chk("post-rst r9", b_rd1, 32'h0);

      // Narrow, non-bypassing instance: write r7, then scoreboard and r0.
      @(negedge clk);
      s_we1 = 1'b1; s_wa1 = 3'd7; s_wd1 = 16'hBEEF;
      s_set_en = 1'b1; s_set_a = 3'd2;
      s_a1 = 3'd2; s_a2 = 3'd7;
      #2;
      chk("s write-cycle rd2", 32'(s_rd2), 32'h0);
      chk("s set-cycle pend1", 32'(s_p1), 32'h0);
      @(negedge clk);
      s_we1 = 1'b1; s_wa1 = 3'd0; s_wd1 = 16'h1234;
      s_set_en = 1'b0;
      #2;
      chk("s next rd2", 32'(s_rd2), 32'hBEEF);
      chk("s next pend1", 32'(s_p1), 32'h1);
      @(negedge clk);
      s_we1 = 1'b0;
      s_a1 = 3'd0;
      #2;
      chk("s r0 rd1", 32'(s_rd1), 32'h0);
      chk("s r7 rd2 hold", 32'(s_rd2), 32'hBEEF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
